// File: rtl/op_input_sequencer.sv
// Input front end for the ALU control FSM: synchronizes and debounces buttons and switches,
// then walks the user through operand A, operand B and the operation.
module op_input_sequencer #(
  parameter int unsigned DB_CYCLES = 250000,
  parameter int unsigned CNT_W     = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_confirm,
  input  logic [1:0] sw_data,
  input  logic [1:0] sw_op,
  output logic [1:0] operand_a,
  output logic [1:0] operand_b,
  output logic [1:0] switch_op,
  output logic       handshaking,
  output logic       confirm_op,
  output logic [1:0] phase
);

  localparam int unsigned SYNC_W = 6;
  localparam int unsigned NBTN   = 2;
  localparam int unsigned BTN_NEXT    = 1;
  localparam int unsigned BTN_CONFIRM = 0;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_GOT_A = 2'b01;
  localparam logic [1:0] S_GOT_B = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_W-1:0]           sync1;
  logic [SYNC_W-1:0]           sync2;
  logic [NBTN-1:0]             btn_s;
  logic [1:0]                  sd_s;
  logic [1:0]                  so_s;
  logic [NBTN-1:0]             db;
  logic [NBTN-1:0]             db_q;
  logic [NBTN-1:0]             press;
  logic [NBTN-1:0][CNT_W-1:0]  cnt;

  logic [1:0] state;
  logic [1:0] nxt_state;
  logic [1:0] nxt_a;
  logic [1:0] nxt_b;
  logic [1:0] nxt_op;
  logic       nxt_hs;
  logic       nxt_co;

  // 2-FF synchronizers for every raw input
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_next, btn_confirm, sw_data, sw_op};
      sync2 <= sync1;
    end
  end

  assign btn_s = {sync2[5], sync2[4]};
  assign sd_s  = sync2[3:2];
  assign so_s  = sync2[1:0];

  // Debounce: level flips only after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      db    <= '0;
      db_q  <= '0;
      press <= '0;
      cnt   <= '0;
    end else begin
      db_q  <= db;
      press <= db & ~db_q;
      for (int i = 0; i < int'(NBTN); i++) begin
        if (btn_s[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          db[i]  <= ~db[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // State and latched outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      operand_a   <= '0;
      operand_b   <= '0;
      switch_op   <= '0;
      handshaking <= 1'b0;
      confirm_op  <= 1'b0;
    end else begin
      state       <= nxt_state;
      operand_a   <= nxt_a;
      operand_b   <= nxt_b;
      switch_op   <= nxt_op;
      handshaking <= nxt_hs;
      confirm_op  <= nxt_co;
    end
  end

  // Each state reacts only to the one press that is meaningful for it
  always_comb begin
    nxt_state = state;
    nxt_a     = operand_a;
    nxt_b     = operand_b;
    nxt_op    = switch_op;
    nxt_hs    = 1'b0;
    nxt_co    = 1'b0;
    case (state)
      S_IDLE: begin
        if (press[BTN_NEXT]) begin
          nxt_a     = sd_s;
          nxt_state = S_GOT_A;
        end
      end
      S_GOT_A: begin
        if (press[BTN_NEXT]) begin
          nxt_b     = sd_s;
          nxt_hs    = 1'b1;
          nxt_state = S_GOT_B;
        end
      end
      S_GOT_B: begin
        if (press[BTN_CONFIRM]) begin
          nxt_op    = so_s;
          nxt_co    = 1'b1;
          nxt_state = S_DONE;
        end
      end
      S_DONE: begin
        if (press[BTN_NEXT]) begin
          nxt_state = S_IDLE;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_op_input_sequencer.sv
// Bench for op_input_sequencer: directed vector table, reset-while-held sequence,
// and randomized stimulus compared every cycle against an edge-indexed reference model.
module tb_op_input_sequencer;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_confirm = 1'b0;
  logic [1:0] sw_data = 2'b00;
  logic [1:0] sw_op = 2'b00;
  logic [1:0] operand_a;
  logic [1:0] operand_b;
  logic [1:0] switch_op;
  logic       handshaking;
  logic       confirm_op;
  logic [1:0] phase;

  always #5 clk = ~clk;

  op_input_sequencer #(.DB_CYCLES(DB), .CNT_W(18)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_confirm(btn_confirm),
    .sw_data(sw_data), .sw_op(sw_op), .operand_a(operand_a), .operand_b(operand_b),
    .switch_op(switch_op), .handshaking(handshaking), .confirm_op(confirm_op), .phase(phase)
  );

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int co_cnt = 0;
  int cyc = 0;

  // Reference model: raw samples per edge, sync value = raw sampled two edges earlier,
  // a level flips once the last DB sync samples all disagree with it,
  // and a rising level acts on the FSM two edges later.
  bit [5:0] m_raw[$] = '{6'd0, 6'd0};
  bit       h_n[$];
  bit       h_c[$];
  bit       db_n, db_c;
  int       tog_n, tog_c;
  int       rise_n = -100, rise_c = -100;
  int       e = 0;
  bit [1:0] m_phase, m_a, m_b, m_op;
  bit       m_hs, m_co;

  function automatic bit all_differ(bit h[$], bit d);
    if (h.size() < int'(DB)) return 1'b0;
    foreach (h[i]) if (h[i] == d) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit [5:0] s;
    if (reset) begin
      m_raw.delete(); m_raw.push_back(6'd0); m_raw.push_back(6'd0);
      h_n.delete(); h_c.delete();
      db_n = 0; db_c = 0; tog_n = e; tog_c = e;
      rise_n = -100; rise_c = -100;
      m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_hs = 0; m_co = 0;
    end else begin
      s = m_raw[0];
      m_hs = 0; m_co = 0;
      case (m_phase)
        2'd0: if (e == rise_n + 2) begin m_a = s[3:2]; m_phase = 2'd1; end
        2'd1: if (e == rise_n + 2) begin m_b = s[3:2]; m_phase = 2'd2; m_hs = 1; end
        2'd2: if (e == rise_c + 2) begin m_op = s[1:0]; m_phase = 2'd3; m_co = 1; end
        default: if (e == rise_n + 2) m_phase = 2'd0;
      endcase
      h_n.push_back(s[5]); if (h_n.size() > int'(DB)) void'(h_n.pop_front());
      h_c.push_back(s[4]); if (h_c.size() > int'(DB)) void'(h_c.pop_front());
      if (e - tog_n >= int'(DB) && all_differ(h_n, db_n)) begin
        db_n = !db_n; tog_n = e; if (db_n) rise_n = e;
      end
      if (e - tog_c >= int'(DB) && all_differ(h_c, db_c)) begin
        db_c = !db_c; tog_c = e; if (db_c) rise_c = e;
      end
      m_raw.push_back({btn_next, btn_confirm, sw_data, sw_op});
      if (m_raw.size() > 2) void'(m_raw.pop_front());
    end
    e++;
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (handshaking) hs_cnt++;
    if (confirm_op) co_cnt++;
    check("model_cmp",
          int'({phase, operand_a, operand_b, switch_op, handshaking, confirm_op}),
          int'({m_phase, m_a, m_b, m_op, m_hs, m_co}));
  endtask

  typedef struct {
    bit       rst, nxt, cnf;
    bit [1:0] sd, so;
    int       n;
    bit [1:0] ph, a, b, op;
    int       hs, co;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int rise_k, trans, hn, hc;
    bit [1:0] prev_ph;

    //            rst nxt cnf  sd    so    n   ph    a     b     op   hs co
    tbl.push_back('{1, 1, 0, 2'd3, 2'd2,  2, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0}); // reset
    tbl.push_back('{0, 0, 0, 2'd0, 2'd0, 20, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0}); // idle
    tbl.push_back('{0, 0, 1, 2'd0, 2'd0, 10, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0}); // confirm in IDLE
    tbl.push_back('{0, 0, 0, 2'd0, 2'd0,  8, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0});
    tbl.push_back('{0, 1, 0, 2'd2, 2'd0, 10, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0}); // latch A
    tbl.push_back('{0, 0, 0, 2'd2, 2'd0,  8, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0});
    tbl.push_back('{0, 1, 0, 2'd1, 2'd0, 10, 2'd2, 2'd2, 2'd1, 2'd0, 1, 0}); // latch B
    tbl.push_back('{0, 0, 0, 2'd1, 2'd0,  8, 2'd2, 2'd2, 2'd1, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 1, 2'd1, 2'd3, 10, 2'd3, 2'd2, 2'd1, 2'd3, 0, 1}); // confirm op
    tbl.push_back('{0, 0, 0, 2'd1, 2'd3,  8, 2'd3, 2'd2, 2'd1, 2'd3, 0, 0});
    tbl.push_back('{0, 1, 0, 2'd1, 2'd3, 10, 2'd0, 2'd2, 2'd1, 2'd3, 0, 0}); // DONE->IDLE keeps values
    tbl.push_back('{0, 0, 0, 2'd1, 2'd3,  8, 2'd0, 2'd2, 2'd1, 2'd3, 0, 0});
    tbl.push_back('{0, 1, 0, 2'd3, 2'd3,  3, 2'd0, 2'd2, 2'd1, 2'd3, 0, 0}); // 3-cycle glitch
    tbl.push_back('{0, 0, 0, 2'd3, 2'd3,  8, 2'd0, 2'd2, 2'd1, 2'd3, 0, 0});
    tbl.push_back('{0, 0, 0, 2'd3, 2'd3,  1, 2'd0, 2'd2, 2'd1, 2'd3, 0, 0}); // bounce 0101
    tbl.push_back('{0, 1, 0, 2'd3, 2'd3,  1, 2'd0, 2'd2, 2'd1, 2'd3, 0, 0});
    tbl.push_back('{0, 0, 0, 2'd3, 2'd3,  1, 2'd0, 2'd2, 2'd1, 2'd3, 0, 0});
    tbl.push_back('{0, 1, 0, 2'd3, 2'd3,  1, 2'd0, 2'd2, 2'd1, 2'd3, 0, 0});
    tbl.push_back('{0, 1, 0, 2'd3, 2'd3, 10, 2'd1, 2'd3, 2'd1, 2'd3, 0, 0}); // then stable high
    tbl.push_back('{0, 0, 0, 2'd3, 2'd3,  8, 2'd1, 2'd3, 2'd1, 2'd3, 0, 0});
    tbl.push_back('{0, 0, 1, 2'd3, 2'd0, 10, 2'd1, 2'd3, 2'd1, 2'd3, 0, 0}); // confirm in GOT_A
    tbl.push_back('{0, 0, 0, 2'd3, 2'd0,  8, 2'd1, 2'd3, 2'd1, 2'd3, 0, 0});
    tbl.push_back('{0, 1, 0, 2'd2, 2'd0, 10, 2'd2, 2'd3, 2'd2, 2'd3, 1, 0});
    tbl.push_back('{0, 0, 0, 2'd2, 2'd0,  8, 2'd2, 2'd3, 2'd2, 2'd3, 0, 0});
    tbl.push_back('{0, 1, 0, 2'd3, 2'd0, 10, 2'd2, 2'd3, 2'd2, 2'd3, 0, 0}); // next in GOT_B
    tbl.push_back('{0, 0, 0, 2'd3, 2'd0,  8, 2'd2, 2'd3, 2'd2, 2'd3, 0, 0});
    tbl.push_back('{0, 1, 1, 2'd3, 2'd1, 10, 2'd3, 2'd3, 2'd2, 2'd1, 0, 1}); // both in GOT_B
    tbl.push_back('{0, 0, 0, 2'd3, 2'd1,  8, 2'd3, 2'd3, 2'd2, 2'd1, 0, 0});
    tbl.push_back('{0, 1, 0, 2'd3, 2'd1, 10, 2'd0, 2'd3, 2'd2, 2'd1, 0, 0});
    tbl.push_back('{0, 0, 0, 2'd3, 2'd1,  8, 2'd0, 2'd3, 2'd2, 2'd1, 0, 0});
    tbl.push_back('{0, 1, 0, 2'd0, 2'd1, 10, 2'd1, 2'd0, 2'd2, 2'd1, 0, 0});
    tbl.push_back('{0, 0, 0, 2'd0, 2'd1,  8, 2'd1, 2'd0, 2'd2, 2'd1, 0, 0});
    tbl.push_back('{0, 1, 0, 2'd1, 2'd1, 10, 2'd2, 2'd0, 2'd1, 2'd1, 1, 0}); // ends in GOT_B, next held

    foreach (tbl[v]) begin
      reset = tbl[v].rst; btn_next = tbl[v].nxt; btn_confirm = tbl[v].cnf;
      sw_data = tbl[v].sd; sw_op = tbl[v].so;
      hs_cnt = 0; co_cnt = 0;
      for (int k = 0; k < tbl[v].n; k++) tick();
      check($sformatf("vec%0d_regs", v),
            int'({phase, operand_a, operand_b, switch_op}),
            int'({tbl[v].ph, tbl[v].a, tbl[v].b, tbl[v].op}));
      check($sformatf("vec%0d_pulses", v), hs_cnt * 16 + co_cnt, tbl[v].hs * 16 + tbl[v].co);
    end

    // Reset for one cycle in GOT_B with btn_next still held
    reset = 1'b1;
    tick();
    check("rst_mid_outputs",
          int'({phase, operand_a, operand_b, switch_op, handshaking, confirm_op}), 0);
    reset = 1'b0;
    hs_cnt = 0; rise_k = -1; trans = 0; prev_ph = phase;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (phase != prev_ph) begin
        trans++;
        if (rise_k < 0) rise_k = k;
      end
      prev_ph = phase;
    end
    check("held_press_edge", rise_k, 7);
    check("held_one_transition", trans, 1);
    check("held_state", int'({phase, operand_a}), int'({2'd1, 2'd1}));
    check("held_no_handshake", hs_cnt, 0);

    btn_next = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    // Randomized phase, compared cycle by cycle against the model
    hn = 0; hc = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hn == 0) begin btn_next = 1'($urandom_range(0, 1)); hn = $urandom_range(1, 12); end
      else hn--;
      if (hc == 0) begin btn_confirm = 1'($urandom_range(0, 1)); hc = $urandom_range(1, 12); end
      else hc--;
      if ($urandom_range(0, 5) == 0) sw_data = 2'($urandom);
      if ($urandom_range(0, 5) == 0) sw_op = 2'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
